// File: rtl/adjacency_stream_server.sv
// ============================================================================
// Module      : adjacency_stream_server
// Description : Compressed adjacency-list store serving one successor per read
// Revision    : 1.0
// ============================================================================
`default_nettype none

module adjacency_stream_server #(
    parameter int NODE_IDX_WIDTH  = 10,
    parameter int COUNTER_WIDTH   = 5,
    parameter int EDGE_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_load,
    input  logic                       load_valid,
    input  logic [NODE_IDX_WIDTH-1:0]  load_src,
    input  logic [NODE_IDX_WIDTH-1:0]  load_dst,
    input  logic                       load_last,
    output logic                       load_ready,
    output logic                       graph_ready,
    output logic                       load_error,
    input  logic                       rd_req,
    input  logic [NODE_IDX_WIDTH-1:0]  rd_node,
    input  logic                       rd_restart,
    output logic                       rd_valid,
    output logic [NODE_IDX_WIDTH-1:0]  rd_dst,
    output logic [COUNTER_WIDTH-1:0]   rd_remaining,
    output logic                       rd_none
);

    localparam int c_NUM_NODES = 1 << NODE_IDX_WIDTH;
    localparam int c_NUM_EDGES = 1 << EDGE_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_LOAD  = 2'd2,
        S_READY = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [COUNTER_WIDTH-1:0]   r_degree_mem [c_NUM_NODES];
    logic [EDGE_ADDR_WIDTH-1:0] r_offset_mem [c_NUM_NODES];
    logic [NODE_IDX_WIDTH-1:0]  r_edge_mem   [c_NUM_EDGES];

    logic [NODE_IDX_WIDTH-1:0]  r_clr_idx;
    logic [EDGE_ADDR_WIDTH:0]   r_edge_cnt;
    logic [NODE_IDX_WIDTH-1:0]  r_prev_src;
    logic                       r_first_beat;
    logic [COUNTER_WIDTH-1:0]   r_cur_deg;
    logic                       r_load_error;

    logic                       w_load_beat;
    logic                       w_new_src;
    logic [COUNTER_WIDTH-1:0]   w_deg_base;
    logic [COUNTER_WIDTH-1:0]   w_deg_inc;
    logic                       w_deg_full;
    logic                       w_edge_full;
    logic                       w_accept;
    logic                       w_drop;

    // Sources arrive grouped, so a running count stands in for a degree RMW
    assign w_load_beat = (r_state == S_LOAD) && load_valid;
    assign w_new_src   = r_first_beat || (load_src != r_prev_src);
    assign w_deg_base  = w_new_src ? '0 : r_cur_deg;
    assign w_deg_inc   = w_deg_base + COUNTER_WIDTH'(1);
    assign w_deg_full  = &w_deg_base;
    assign w_edge_full = r_edge_cnt[EDGE_ADDR_WIDTH];
    assign w_accept    = w_load_beat && !w_deg_full && !w_edge_full;
    assign w_drop      = w_load_beat && (w_deg_full || w_edge_full);

    assign load_ready  = (r_state == S_LOAD);
    assign graph_ready = (r_state == S_READY);
    assign load_error  = r_load_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_load) w_state_next = S_CLEAR;
            S_CLEAR: if (&r_clr_idx) w_state_next = S_LOAD;
            S_LOAD:  if (w_accept && load_last) w_state_next = S_READY;
            S_READY: if (start_load) w_state_next = S_CLEAR;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_idx    <= '0;
            r_edge_cnt   <= '0;
            r_prev_src   <= '0;
            r_first_beat <= 1'b1;
            r_cur_deg    <= '0;
            r_load_error <= 1'b0;
        end else begin
            r_clr_idx <= (r_state == S_CLEAR) ? r_clr_idx + NODE_IDX_WIDTH'(1) : '0;
            if (r_state == S_CLEAR) begin
                r_edge_cnt   <= '0;
                r_load_error <= 1'b0;
                r_first_beat <= 1'b1;
                r_cur_deg    <= '0;
            end
            if (w_load_beat) begin
                r_prev_src   <= load_src;
                r_first_beat <= 1'b0;
                r_cur_deg    <= w_accept ? w_deg_inc : w_deg_base;
            end
            if (w_accept) begin
                r_edge_cnt <= r_edge_cnt + (EDGE_ADDR_WIDTH + 1)'(1);
            end
            if (w_drop) begin
                r_load_error <= 1'b1;
            end
        end
    end

    // ---------------- read pipeline ----------------
    logic                       r_s1_valid;
    logic [NODE_IDX_WIDTH-1:0]  r_s1_node;
    logic                       r_s1_restart;
    logic [COUNTER_WIDTH-1:0]   r_s1_degree;
    logic [EDGE_ADDR_WIDTH-1:0] r_s1_offset;

    logic [NODE_IDX_WIDTH-1:0]  r_cur_node;
    logic [COUNTER_WIDTH-1:0]   r_cursor;
    logic                       r_rd_first;

    logic                       r_s2_valid;
    logic                       r_s2_hit;
    logic [COUNTER_WIDTH-1:0]   r_s2_remaining;
    logic [NODE_IDX_WIDTH-1:0]  r_s2_edge;

    logic                       w_req_accept;
    logic [COUNTER_WIDTH-1:0]   w_s1_cursor;
    logic                       w_s1_hit;
    logic [EDGE_ADDR_WIDTH-1:0] w_s1_addr;
    logic [COUNTER_WIDTH-1:0]   w_s1_remaining;

    assign w_req_accept   = rd_req && (r_state == S_READY);
    // Cursor is committed in stage 1, so a back-to-back request sees it directly
    assign w_s1_cursor    = (r_s1_restart || r_rd_first || (r_s1_node != r_cur_node))
                            ? '0 : r_cursor;
    assign w_s1_hit       = w_s1_cursor < r_s1_degree;
    assign w_s1_addr      = r_s1_offset + EDGE_ADDR_WIDTH'(w_s1_cursor);
    assign w_s1_remaining = r_s1_degree - w_s1_cursor - COUNTER_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_degree_mem[r_clr_idx] <= '0;
        end else if (w_accept) begin
            r_degree_mem[load_src] <= w_deg_inc;
        end
        if (w_accept) begin
            r_edge_mem[r_edge_cnt[EDGE_ADDR_WIDTH-1:0]] <= load_dst;
            if (w_new_src) begin
                r_offset_mem[load_src] <= r_edge_cnt[EDGE_ADDR_WIDTH-1:0];
            end
        end
        r_s1_degree <= r_degree_mem[rd_node];
        r_s1_offset <= r_offset_mem[rd_node];
        r_s2_edge   <= r_edge_mem[w_s1_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_node      <= '0;
            r_s1_restart   <= 1'b0;
            r_cur_node     <= '0;
            r_cursor       <= '0;
            r_rd_first     <= 1'b1;
            r_s2_valid     <= 1'b0;
            r_s2_hit       <= 1'b0;
            r_s2_remaining <= '0;
            rd_valid       <= 1'b0;
            rd_dst         <= '0;
            rd_remaining   <= '0;
            rd_none        <= 1'b0;
        end else begin
            r_s1_valid   <= w_req_accept;
            r_s1_node    <= rd_node;
            r_s1_restart <= rd_restart;

            if (r_s1_valid) begin
                r_cur_node <= r_s1_node;
                r_cursor   <= w_s1_hit ? w_s1_cursor + COUNTER_WIDTH'(1) : w_s1_cursor;
            end
            if (r_state != S_READY) begin
                r_rd_first <= 1'b1;
            end else if (r_s1_valid) begin
                r_rd_first <= 1'b0;
            end

            r_s2_valid     <= r_s1_valid;
            r_s2_hit       <= w_s1_hit;
            r_s2_remaining <= w_s1_remaining;

            rd_valid     <= r_s2_valid;
            rd_dst       <= (r_s2_valid && r_s2_hit) ? r_s2_edge : '0;
            rd_remaining <= (r_s2_valid && r_s2_hit) ? r_s2_remaining : '0;
            rd_none      <= r_s2_valid && !r_s2_hit;
        end
    end

endmodule

`default_nettype wire
